// File: rtl/mlp_mac_seq.sv
// mlp_mac_seq: command-driven dot-product sequencer for one MLP MAC.
// Fetches x/w pairs, streams them as MAC beats, returns a saturated result.
module mlp_mac_seq #(
  parameter int A_WIDTH    = 16,
  parameter int B_WIDTH    = 16,
  parameter int ACC_WIDTH  = 64,
  parameter int OUT_WIDTH  = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [ADDR_WIDTH-1:0] cmd_xbase,
  input  logic [ADDR_WIDTH-1:0] cmd_wbase,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] x_addr,
  output logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [A_WIDTH-1:0]    x_rdata,
  input  logic [B_WIDTH-1:0]    w_rdata,
  output logic                  mac_start,
  output logic                  mac_valid,
  output logic [A_WIDTH-1:0]    mac_a,
  output logic [B_WIDTH-1:0]    mac_b,
  input  logic [ACC_WIDTH-1:0]  mac_result,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [OUT_WIDTH-1:0]  res_data,
  output logic                  res_sat
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_CAPT,
    S_DONE
  } state_t;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] xbase_q, xbase_d;
  logic [ADDR_WIDTH-1:0] wbase_q, wbase_d;
  logic [OUT_WIDTH-1:0]  res_data_q, res_data_d;
  logic                  res_sat_q, res_sat_d;
  logic                  beat_q, first_q;

  logic signed [ACC_WIDTH-1:0] acc_s;
  logic [OUT_WIDTH-1:0]        sat_data;
  logic                        sat_flag;

  assign acc_s = $signed(mac_result);

  always_comb begin
    sat_data = acc_s[OUT_WIDTH-1:0];
    sat_flag = 1'b0;
    if (acc_s > SAT_MAX) begin
      sat_data = SAT_MAX[OUT_WIDTH-1:0];
      sat_flag = 1'b1;
    end else if (acc_s < SAT_MIN) begin
      sat_data = SAT_MIN[OUT_WIDTH-1:0];
      sat_flag = 1'b1;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign res_valid = (state_q == S_DONE);
  assign res_data  = res_data_q;
  assign res_sat   = res_sat_q;

  // A zero-length command spends one FETCH cycle without reading.
  assign rd_en  = (state_q == S_FETCH) && (len_q != '0);
  assign x_addr = rd_en ? xbase_q + ADDR_WIDTH'(idx_q) : '0;
  assign w_addr = rd_en ? wbase_q + ADDR_WIDTH'(idx_q) : '0;

  assign mac_start = beat_q & first_q;
  assign mac_valid = beat_q & ~first_q;
  assign mac_a     = beat_q ? x_rdata : '0;
  assign mac_b     = beat_q ? w_rdata : '0;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    xbase_d    = xbase_q;
    wbase_d    = wbase_q;
    res_data_d = res_data_q;
    res_sat_d  = res_sat_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          len_d      = cmd_len;
          xbase_d    = cmd_xbase;
          wbase_d    = cmd_wbase;
          idx_d      = '0;
          res_data_d = '0;
          res_sat_d  = 1'b0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        if (len_q == '0) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
          if (idx_q == len_q - 1'b1) state_d = S_DRAIN;
        end
      end
      S_DRAIN: state_d = S_CAPT;
      S_CAPT: begin
        res_data_d = sat_data;
        res_sat_d  = sat_flag;
        state_d    = S_DONE;
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      xbase_q    <= '0;
      wbase_q    <= '0;
      res_data_q <= '0;
      res_sat_q  <= 1'b0;
      beat_q     <= 1'b0;
      first_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      xbase_q    <= xbase_d;
      wbase_q    <= wbase_d;
      res_data_q <= res_data_d;
      res_sat_q  <= res_sat_d;
      beat_q     <= rd_en;
      first_q    <= rd_en && (idx_q == '0);
    end
  end

endmodule

// File: tb/tb_mlp_mac_seq.sv
// tb_mlp_mac_seq: directed bench with RAM and MAC models around mlp_mac_seq.
// Expected results are hand-computed constants.
module tb_mlp_mac_seq;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [7:0]         cmd_len = '0;
  logic [7:0]         cmd_xbase = '0;
  logic [7:0]         cmd_wbase = '0;
  logic               rd_en;
  logic [7:0]         x_addr, w_addr;
  logic signed [15:0] x_rdata = '0;
  logic signed [15:0] w_rdata = '0;
  logic               mac_start, mac_valid;
  logic signed [15:0] mac_a, mac_b;
  logic signed [63:0] mac_result;
  logic               res_valid;
  logic               res_ready = 1'b0;
  logic [15:0]        res_data;
  logic               res_sat;

  logic signed [15:0] xmem [256];
  logic signed [15:0] wmem [256];
  logic signed [63:0] acc;
  logic signed [63:0] prod;

  int checks = 0;
  int errors = 0;
  int n_rd = 0;
  int n_start = 0;
  int n_valid = 0;
  int n_both = 0;
  logic [7:0] xa_log [1024];
  logic [7:0] wa_log [1024];

  mlp_mac_seq dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_len(cmd_len), .cmd_xbase(cmd_xbase),
    .cmd_wbase(cmd_wbase), .rd_en(rd_en),
    .x_addr(x_addr), .w_addr(w_addr),
    .x_rdata(x_rdata), .w_rdata(w_rdata),
    .mac_start(mac_start), .mac_valid(mac_valid),
    .mac_a(mac_a), .mac_b(mac_b),
    .mac_result(mac_result), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data),
    .res_sat(res_sat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) begin
      x_rdata <= xmem[x_addr];
      w_rdata <= wmem[w_addr];
    end
  end

  assign prod = mac_a * mac_b;
  assign mac_result = acc >>> 8;
  always @(posedge clk) begin
    if (mac_start) acc <= prod;
    else if (mac_valid) acc <= acc + prod;
  end

  always @(negedge clk) begin
    if (rd_en) begin
      if (n_rd < 1024) begin
        xa_log[n_rd] = x_addr;
        wa_log[n_rd] = w_addr;
      end
      n_rd++;
    end
    if (mac_start) n_start++;
    if (mac_valid) n_valid++;
    if (mac_start && mac_valid) n_both++;
  end

  task automatic run_cmd(input logic [7:0] l, input logic [7:0] xb,
                         input logic [7:0] wb, output int lat);
    cmd_valid = 1'b1;
    cmd_len   = l;
    cmd_xbase = xb;
    cmd_wbase = wb;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rd_en, mac_start, mac_valid, res_valid, res_sat} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000",
               {rd_en, mac_start, mac_valid, res_valid, res_sat});
    end
    checks++;
    if (res_data !== 16'h0) begin
      errors++;
      $display("FAIL reset_data got %h want 0000", res_data);
    end
    checks++;
    if ({x_addr, w_addr} !== 16'h0) begin
      errors++;
      $display("FAIL reset_addr got %h want 0000", {x_addr, w_addr});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_dot4();
    int lat, s0, v0;
    xmem[0] = 256; xmem[1] = 512; xmem[2] = 768; xmem[3] = 1024;
    for (int i = 0; i < 4; i++) wmem[8'h20 + i] = 256;
    s0 = n_start; v0 = n_valid;
    run_cmd(8'd4, 8'h00, 8'h20, lat);
    checks++;
    if (lat != 6) begin
      errors++;
      $display("FAIL dot4_latency got %0d want 6", lat);
    end
    checks++;
    if (res_data !== 16'd2560 || res_sat !== 1'b0) begin
      errors++;
      $display("FAIL dot4_result got %0d/%b want 2560/0", res_data, res_sat);
    end
    checks++;
    if (n_start - s0 != 1 || n_valid - v0 != 3) begin
      errors++;
      $display("FAIL dot4_beats got %0d/%0d want 1/3",
               n_start - s0, n_valid - v0);
    end
    consume();
    checks++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL dot4_release got %b%b want 01", res_valid, cmd_ready);
    end
  endtask

  task automatic test_saturation();
    int lat;
    xmem[8'h30] = 32767; xmem[8'h31] = 32767;
    wmem[8'h40] = 32767; wmem[8'h41] = 32767;
    run_cmd(8'd2, 8'h30, 8'h40, lat);
    checks++;
    if (res_data !== 16'h7FFF || res_sat !== 1'b1) begin
      errors++;
      $display("FAIL sat_pos got %h/%b want 7fff/1", res_data, res_sat);
    end
    consume();
    xmem[8'h32] = -32768; xmem[8'h33] = -32768;
    run_cmd(8'd2, 8'h32, 8'h40, lat);
    checks++;
    if (res_data !== 16'h8000 || res_sat !== 1'b1) begin
      errors++;
      $display("FAIL sat_neg got %h/%b want 8000/1", res_data, res_sat);
    end
    consume();
  endtask

  task automatic test_zero_len();
    int lat, r0, s0, v0;
    r0 = n_rd; s0 = n_start; v0 = n_valid;
    run_cmd(8'd0, 8'h55, 8'h66, lat);
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL zero_latency got %0d want 1", lat);
    end
    checks++;
    if (res_data !== 16'h0 || res_sat !== 1'b0) begin
      errors++;
      $display("FAIL zero_result got %h/%b want 0000/0", res_data, res_sat);
    end
    checks++;
    if (n_rd != r0 || n_start != s0 || n_valid != v0) begin
      errors++;
      $display("FAIL zero_beats got %0d/%0d/%0d want 0/0/0",
               n_rd - r0, n_start - s0, n_valid - v0);
    end
    consume();
  endtask

  task automatic test_hold();
    int lat, r0;
    xmem[8'h70] = 256; wmem[8'h71] = 256;
    run_cmd(8'd1, 8'h70, 8'h71, lat);
    cmd_valid = 1'b1;
    cmd_len   = 8'd0;
    r0 = n_rd;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (res_valid !== 1'b1 || res_data !== 16'd256 ||
          cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d got %b/%0d/%b want 1/256/0",
                 i, res_valid, res_data, cmd_ready);
      end
    end
    checks++;
    if (n_rd != r0) begin
      errors++;
      $display("FAIL hold_reads got %0d want 0", n_rd - r0);
    end
    consume();
    checks++;
    if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_idle got %b%b want 10", cmd_ready, res_valid);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL hold_accept got %b want 0", cmd_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b1 || res_data !== 16'h0) begin
      errors++;
      $display("FAIL hold_next got %b/%h want 1/0000", res_valid, res_data);
    end
    consume();
  endtask

  task automatic test_addr_wrap();
    int lat, r0;
    logic [7:0] xe [4];
    logic [7:0] we [4];
    xe = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    we = '{8'h10, 8'h11, 8'h12, 8'h13};
    r0 = n_rd;
    run_cmd(8'd4, 8'hFE, 8'h10, lat);
    checks++;
    if (n_rd - r0 != 4) begin
      errors++;
      $display("FAIL wrap_count got %0d want 4", n_rd - r0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (xa_log[r0 + i] !== xe[i] || wa_log[r0 + i] !== we[i]) begin
        errors++;
        $display("FAIL wrap_addr%0d got %h/%h want %h/%h",
                 i, xa_log[r0 + i], wa_log[r0 + i], xe[i], we[i]);
      end
    end
    consume();
  endtask

  task automatic test_mid_reset();
    int lat, s0, v0;
    cmd_valid = 1'b1;
    cmd_len   = 8'd8;
    cmd_xbase = 8'h80;
    cmd_wbase = 8'h90;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({rd_en, mac_start, mac_valid, res_valid, res_sat} !== 5'b0 ||
        res_data !== 16'h0 || {x_addr, w_addr} !== 16'h0) begin
      errors++;
      $display("FAIL midrst_outs got %b %h %h want 00000 0000 0000",
               {rd_en, mac_start, mac_valid, res_valid, res_sat},
               res_data, {x_addr, w_addr});
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_idle got %b want 1", cmd_ready);
    end
    rst_n = 1'b1;
    xmem[8'h40] = 300; wmem[8'h50] = -200;
    s0 = n_start; v0 = n_valid;
    run_cmd(8'd1, 8'h40, 8'h50, lat);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL midrst_latency got %0d want 3", lat);
    end
    checks++;
    if (res_data !== 16'hFF15 || res_sat !== 1'b0) begin
      errors++;
      $display("FAIL midrst_result got %h/%b want ff15/0", res_data, res_sat);
    end
    checks++;
    if (n_start - s0 != 1 || n_valid - v0 != 0 || n_both != 0) begin
      errors++;
      $display("FAIL midrst_beats got %0d/%0d/%0d want 1/0/0",
               n_start - s0, n_valid - v0, n_both);
    end
    consume();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      xmem[i] = '0;
      wmem[i] = '0;
    end
    for (int i = 0; i < 4; i++) begin
      xmem[(8'hFE + i) % 256] = 256;
      wmem[8'h10 + i] = 256;
    end
    test_reset();
    test_dot4();
    test_saturation();
    test_zero_len();
    test_hold();
    test_addr_wrap();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
